// File: rtl/fifo_bank_writer.sv
// Drains a non-FWFT FIFO into one half of a ping-pong dual-port RAM in fixed bursts,
// reports each filled bank and waits for the reader to hand it back before reuse.
module fifo_bank_writer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_rd_empty,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              bank_done,
    output logic              bank_id,
    input  logic              bank_release,
    input  logic              release_id,
    output logic [1:0]        bank_full
);

    localparam int OFF_W = ADDR_W - 1;
    localparam logic [ADDR_W-1:0] BANK_DEPTH = {1'b1, {OFF_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ISSUE_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [OFF_W-1:0]  OFF_ONE    = {{(OFF_W-1){1'b0}}, 1'b1};
    localparam logic [OFF_W-1:0]  OFF_LAST   = {OFF_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                rd_en_s;
    logic                go_done_s;
    logic [1:0]          full_s;
    logic [ADDR_W-1:0]   issued_r;
    logic [OFF_W-1:0]    offset_r;
    logic                wr_bank_r;
    logic                ram_wr_en_r;
    logic                bank_done_r;
    logic                bank_id_r;
    logic [1:0]          bank_full_r;

    // Next-state and read-strobe decode
    always_comb begin
        state_s   = state_r;
        rd_en_s   = 1'b0;
        go_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!bank_full_r[wr_bank_r] && !fifo_rd_empty) begin
                    state_s = ST_BURST;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                rd_en_s = !fifo_rd_empty && (issued_r < BANK_DEPTH);
                // The burst ends on the write of the last offset, not on the last read.
                if (ram_wr_en_r && (offset_r == OFF_LAST)) begin
                    state_s   = ST_DONE;
                    go_done_s = 1'b1;
                end else begin
                    state_s = ST_BURST;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Bank ownership: reader release clears, completed bank sets; set wins on a clash
    always_comb begin
        full_s = bank_full_r;
        if (bank_release) begin
            full_s[release_id] = 1'b0;
        end else begin
            full_s = bank_full_r;
        end
        if (state_r == ST_DONE) begin
            full_s[wr_bank_r] = 1'b1;
        end else begin
            full_s = full_s;
        end
    end

    // State, flags and registered write strobe
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            bank_full_r <= 2'b00;
            ram_wr_en_r <= 1'b0;
            bank_done_r <= 1'b0;
            bank_id_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            bank_full_r <= full_s;
            ram_wr_en_r <= rd_en_s;
            bank_done_r <= go_done_s;
            if (go_done_s) begin
                bank_id_r <= wr_bank_r;
            end else begin
                bank_id_r <= bank_id_r;
            end
        end
    end

    // Read-issue counter, write offset and active bank
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issued_r  <= {ADDR_W{1'b0}};
            offset_r  <= {OFF_W{1'b0}};
            wr_bank_r <= 1'b0;
        end else begin
            if (state_r == ST_DONE) begin
                issued_r  <= {ADDR_W{1'b0}};
                wr_bank_r <= ~wr_bank_r;
            end else if (rd_en_s) begin
                issued_r  <= issued_r + ISSUE_ONE;
            end else begin
                issued_r  <= issued_r;
            end
            // Offset naturally wraps to zero on the bank's final write.
            if (ram_wr_en_r) begin
                offset_r <= offset_r + OFF_ONE;
            end else begin
                offset_r <= offset_r;
            end
        end
    end

    assign fifo_rd_en  = rd_en_s;
    assign ram_wr_en   = ram_wr_en_r;
    assign ram_wr_addr = {wr_bank_r, offset_r};
    assign ram_wr_data = ram_wr_en_r ? fifo_rd_data : {DATA_W{1'b0}};
    assign bank_done   = bank_done_r;
    assign bank_id     = bank_id_r;
    assign bank_full   = bank_full_r;

endmodule
